// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard tracker: opcodes, forwarding codes,
// the shadow-pipeline slot record and the slot match helper.
package hazard_pkg;

    localparam int WIDTH_DATA_LENGTH = 32;
    localparam int CNT_WIDTH         = 16;

    // Forwarding codes driven onto the operand muxes and the stall controller
    localparam logic [1:0] No_Fw  = 2'b00;
    localparam logic [1:0] WB_Fw  = 2'b01;
    localparam logic [1:0] MEM_Fw = 2'b10;

    // RV32I major opcodes recognised by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // One shadow-pipeline slot; valid=0 marks a bubble
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic       reg_wr;
        logic       is_load;
    } slot_t;

    // True when producer slot s writes the register the EX operand reads.
    // Writes to x0 are discarded by the register file, so they never forward.
    function automatic logic slot_matches(slot_t s, logic use_r, logic [4:0] r);
        return s.valid && s.reg_wr && (s.rd != 5'd0) && use_r && (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_tracker_decode.sv
// Combinational decoder: instruction word to slot fields.
module hazard_decode
    import hazard_pkg::*;
(
    input  logic [WIDTH_DATA_LENGTH-1:0] inst_i,
    output slot_t                        slot_o
);

    // funct3/funct7 bits do not influence register usage
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_i[31:25], inst_i[14:12]};

    // Register fields are taken verbatim; flags come from the opcode only
    always_comb begin
        slot_o       = '0;
        slot_o.valid = 1'b1;
        slot_o.rd    = inst_i[11:7];
        slot_o.rs1   = inst_i[19:15];
        slot_o.rs2   = inst_i[24:20];
        case (inst_i[6:0])
            OP_LOAD: begin
                slot_o.reg_wr  = 1'b1;
                slot_o.use_rs1 = 1'b1;
                slot_o.is_load = 1'b1;
            end
            OP_IMM, OP_JALR: begin
                slot_o.reg_wr  = 1'b1;
                slot_o.use_rs1 = 1'b1;
            end
            OP_AUIPC, OP_LUI, OP_JAL: begin
                slot_o.reg_wr  = 1'b1;
            end
            OP_REG: begin
                slot_o.reg_wr  = 1'b1;
                slot_o.use_rs1 = 1'b1;
                slot_o.use_rs2 = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                slot_o.use_rs1 = 1'b1;
                slot_o.use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hazard_tracker.sv
// Shadow pipeline (EX/MEM/WB) of destination metadata producing forwarding
// selects, the combined forwarding code, the MEM load flag and saturating
// stall/flush event counters. Outputs depend only on registered state.
module hazard_tracker
    import hazard_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_DATA_LENGTH-1:0] Inst_DE,
    input  logic                         DE_EX_Reg_EN,
    input  logic                         DE_EX_Reg_RST,
    input  logic                         EX_MEM_Reg_RST,
    input  logic                         Stall_Detected,
    output logic [1:0]                   Fw_Sel_Rs1,
    output logic [1:0]                   Fw_Sel_Rs2,
    output logic [1:0]                   Fw_Detected,
    output logic                         Mem_Load,
    output logic [CNT_WIDTH-1:0]         Stall_Count,
    output logic [CNT_WIDTH-1:0]         Flush_Count
);

    slot_t dec_slot;
    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic mem_hit_rs1, mem_hit_rs2, wb_hit_rs1, wb_hit_rs2;

    hazard_decode u_decode (
        .inst_i (Inst_DE),
        .slot_o (dec_slot)
    );

    // Next slot contents mirror the datapath pipeline registers
    always_comb begin
        ex_d = ex_q;
        if (DE_EX_Reg_RST) begin
            ex_d = '0;
        end else if (DE_EX_Reg_EN) begin
            ex_d = dec_slot;
        end
        mem_d = EX_MEM_Reg_RST ? '0 : ex_q;
        wb_d  = mem_q;
    end

    // Saturating event counters: stop at all-ones instead of wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (Stall_Detected && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (DE_EX_Reg_RST && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers; reset wins over every flush/enable and over counting
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Forwarding decode from slot state; MEM is the younger producer so it wins
    always_comb begin
        mem_hit_rs1 = ex_q.valid && slot_matches(mem_q, ex_q.use_rs1, ex_q.rs1);
        mem_hit_rs2 = ex_q.valid && slot_matches(mem_q, ex_q.use_rs2, ex_q.rs2);
        wb_hit_rs1  = ex_q.valid && slot_matches(wb_q,  ex_q.use_rs1, ex_q.rs1);
        wb_hit_rs2  = ex_q.valid && slot_matches(wb_q,  ex_q.use_rs2, ex_q.rs2);

        Fw_Sel_Rs1 = mem_hit_rs1 ? MEM_Fw : (wb_hit_rs1 ? WB_Fw : No_Fw);
        Fw_Sel_Rs2 = mem_hit_rs2 ? MEM_Fw : (wb_hit_rs2 ? WB_Fw : No_Fw);

        if ((Fw_Sel_Rs1 == MEM_Fw) || (Fw_Sel_Rs2 == MEM_Fw)) begin
            Fw_Detected = MEM_Fw;
        end else if ((Fw_Sel_Rs1 == WB_Fw) || (Fw_Sel_Rs2 == WB_Fw)) begin
            Fw_Detected = WB_Fw;
        end else begin
            Fw_Detected = No_Fw;
        end

        Mem_Load    = mem_q.valid && mem_q.is_load;
        Stall_Count = stall_cnt_q;
        Flush_Count = flush_cnt_q;
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: forwarding, load-use, x0, priority,
// flushes, counter saturation and mid-stream reset.
module tb_hazard_tracker;

    localparam logic [1:0] NO  = 2'b00;
    localparam logic [1:0] WB  = 2'b01;
    localparam logic [1:0] MEM = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Inst_DE;
    logic        DE_EX_Reg_EN;
    logic        DE_EX_Reg_RST;
    logic        EX_MEM_Reg_RST;
    logic        Stall_Detected;
    logic [1:0]  Fw_Sel_Rs1, Fw_Sel_Rs2, Fw_Detected;
    logic        Mem_Load;
    logic [15:0] Stall_Count, Flush_Count;

    int checks   = 0;
    int failures = 0;

    hazard_tracker dut (
        .clk            (clk),
        .rst            (rst),
        .Inst_DE        (Inst_DE),
        .DE_EX_Reg_EN   (DE_EX_Reg_EN),
        .DE_EX_Reg_RST  (DE_EX_Reg_RST),
        .EX_MEM_Reg_RST (EX_MEM_Reg_RST),
        .Stall_Detected (Stall_Detected),
        .Fw_Sel_Rs1     (Fw_Sel_Rs1),
        .Fw_Sel_Rs2     (Fw_Sel_Rs2),
        .Fw_Detected    (Fw_Detected),
        .Mem_Load       (Mem_Load),
        .Stall_Count    (Stall_Count),
        .Flush_Count    (Flush_Count)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // instruction encoders
    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2,
                                          logic [4:0] rs1, logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd,
                                          logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    // one clock; outputs settle 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] i_add, i_sub, i_nop, i_lw, i_use, i_wx0, i_rdx0;
    logic [31:0] i_x9a, i_x9b, i_rd9, i_imm9;

    initial begin
        i_add  = enc_r(7'b0000000, 5'd2, 5'd1, 5'd5);          // add  x5,x1,x2
        i_sub  = enc_r(7'b0100000, 5'd3, 5'd5, 5'd6);          // sub  x6,x5,x3
        i_nop  = enc_i(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011); // addi x0,x0,0
        i_lw   = enc_i(12'd0, 5'd1, 3'b010, 5'd7, 7'b0000011); // lw   x7,0(x1)
        i_use  = enc_r(7'b0000000, 5'd7, 5'd7, 5'd8);          // add  x8,x7,x7
        i_wx0  = enc_i(12'd5, 5'd1, 3'b000, 5'd0, 7'b0010011); // addi x0,x1,5
        i_rdx0 = enc_r(7'b0000000, 5'd0, 5'd0, 5'd11);         // add  x11,x0,x0
        i_x9a  = enc_i(12'd1, 5'd1, 3'b000, 5'd9, 7'b0010011); // addi x9,x1,1
        i_x9b  = enc_i(12'd2, 5'd2, 3'b000, 5'd9, 7'b0010011); // addi x9,x2,2
        i_rd9  = enc_r(7'b0000000, 5'd9, 5'd9, 5'd12);         // add  x12,x9,x9
        i_imm9 = enc_i(12'd9, 5'd2, 3'b000, 5'd14, 7'b0010011);// addi x14,x2,9

        // reset
        rst = 1'b1; Inst_DE = '0; DE_EX_Reg_EN = 1'b0; DE_EX_Reg_RST = 1'b0;
        EX_MEM_Reg_RST = 1'b0; Stall_Detected = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_sel1", 16'(Fw_Sel_Rs1), 16'(NO));
        chk("rst_sel2", 16'(Fw_Sel_Rs2), 16'(NO));
        chk("rst_det", 16'(Fw_Detected), 16'(NO));
        chk("rst_memload", 16'(Mem_Load), 16'd0);
        chk("rst_stallcnt", Stall_Count, 16'd0);
        chk("rst_flushcnt", Flush_Count, 16'd0);

        // back-to-back dependency through MEM
        DE_EX_Reg_EN = 1'b1;
        Inst_DE = i_add; step();
        Inst_DE = i_sub; step();
        chk("b2b_sel1", 16'(Fw_Sel_Rs1), 16'(MEM));
        chk("b2b_sel2", 16'(Fw_Sel_Rs2), 16'(NO));
        chk("b2b_det", 16'(Fw_Detected), 16'(MEM));

        // dependency at distance two forwards from WB
        Inst_DE = i_add; step();
        Inst_DE = i_nop; step();
        Inst_DE = i_sub; step();
        chk("wb_sel1", 16'(Fw_Sel_Rs1), 16'(WB));
        chk("wb_sel2", 16'(Fw_Sel_Rs2), 16'(NO));
        chk("wb_det", 16'(Fw_Detected), 16'(WB));

        // load-use
        Inst_DE = i_nop; step(); step(); step();
        Inst_DE = i_lw;  step();
        Inst_DE = i_use; step();
        chk("lu_memload", 16'(Mem_Load), 16'd1);
        chk("lu_sel1", 16'(Fw_Sel_Rs1), 16'(MEM));
        chk("lu_sel2", 16'(Fw_Sel_Rs2), 16'(MEM));
        chk("lu_det", 16'(Fw_Detected), 16'(MEM));
        Stall_Detected = 1'b1; DE_EX_Reg_EN = 1'b0; EX_MEM_Reg_RST = 1'b1;
        step();
        Stall_Detected = 1'b0; DE_EX_Reg_EN = 1'b1; EX_MEM_Reg_RST = 1'b0;
        chk("stall_sel1", 16'(Fw_Sel_Rs1), 16'(WB));
        chk("stall_sel2", 16'(Fw_Sel_Rs2), 16'(WB));
        chk("stall_det", 16'(Fw_Detected), 16'(WB));
        chk("stall_memload", 16'(Mem_Load), 16'd0);
        chk("stall_cnt1", Stall_Count, 16'd1);
        chk("stall_flushcnt", Flush_Count, 16'd0);

        // writes to x0 never forward
        Inst_DE = i_wx0;  step();
        Inst_DE = i_rdx0; step();
        chk("x0_sel1", 16'(Fw_Sel_Rs1), 16'(NO));
        chk("x0_sel2", 16'(Fw_Sel_Rs2), 16'(NO));
        chk("x0_det", 16'(Fw_Detected), 16'(NO));

        // MEM beats WB for the same register
        Inst_DE = i_x9a; step();
        Inst_DE = i_x9b; step();
        Inst_DE = i_rd9; step();
        chk("prio_sel1", 16'(Fw_Sel_Rs1), 16'(MEM));
        chk("prio_sel2", 16'(Fw_Sel_Rs2), 16'(MEM));
        // immediate bits in the rs2 field must not count as a read
        Inst_DE = i_imm9; step();
        chk("imm_sel1", 16'(Fw_Sel_Rs1), 16'(NO));
        chk("imm_sel2", 16'(Fw_Sel_Rs2), 16'(NO));
        chk("imm_det", 16'(Fw_Detected), 16'(NO));

        // branch flush of EX
        Inst_DE = i_add; step();
        Inst_DE = i_sub; step();
        DE_EX_Reg_RST = 1'b1; step();
        DE_EX_Reg_RST = 1'b0;
        chk("fl_sel1", 16'(Fw_Sel_Rs1), 16'(NO));
        chk("fl_sel2", 16'(Fw_Sel_Rs2), 16'(NO));
        chk("fl_det", 16'(Fw_Detected), 16'(NO));
        chk("fl_cnt1", Flush_Count, 16'd1);

        // simultaneous EX and MEM flush
        Inst_DE = i_lw;  step();
        Inst_DE = i_use; step();
        chk("fl2_pre_memload", 16'(Mem_Load), 16'd1);
        DE_EX_Reg_RST = 1'b1; EX_MEM_Reg_RST = 1'b1; step();
        DE_EX_Reg_RST = 1'b0; EX_MEM_Reg_RST = 1'b0;
        chk("fl2_memload", 16'(Mem_Load), 16'd0);
        chk("fl2_sel1", 16'(Fw_Sel_Rs1), 16'(NO));
        chk("fl2_cnt2", Flush_Count, 16'd2);
        Inst_DE = i_use; step();
        chk("fl2_after_sel1", 16'(Fw_Sel_Rs1), 16'(NO));
        chk("fl2_after_det", 16'(Fw_Detected), 16'(NO));

        // stall counter saturation: 1 + 65533 = 16'hFFFE
        Inst_DE = i_nop;
        Stall_Detected = 1'b1;
        for (int n = 0; n < 65533; n++) step();
        chk("sat_fffe", Stall_Count, 16'hFFFE);
        step();
        chk("sat_ffff_1", Stall_Count, 16'hFFFF);
        step();
        chk("sat_ffff_2", Stall_Count, 16'hFFFF);
        step();
        chk("sat_ffff_3", Stall_Count, 16'hFFFF);
        chk("sat_flushcnt", Flush_Count, 16'd2);

        // reset in the middle of a stall and flush
        Inst_DE = i_add; step();
        Inst_DE = i_sub; step();
        chk("pre_rst_sel1", 16'(Fw_Sel_Rs1), 16'(MEM));
        rst = 1'b1; DE_EX_Reg_RST = 1'b1; step();
        chk("mid_rst_sel1", 16'(Fw_Sel_Rs1), 16'(NO));
        chk("mid_rst_sel2", 16'(Fw_Sel_Rs2), 16'(NO));
        chk("mid_rst_det", 16'(Fw_Detected), 16'(NO));
        chk("mid_rst_memload", 16'(Mem_Load), 16'd0);
        chk("mid_rst_stallcnt", Stall_Count, 16'd0);
        chk("mid_rst_flushcnt", Flush_Count, 16'd0);
        rst = 1'b0; DE_EX_Reg_RST = 1'b0; Stall_Detected = 1'b0;
        Inst_DE = i_sub; step();
        chk("post_rst_sel1", 16'(Fw_Sel_Rs1), 16'(NO));
        chk("post_rst_stallcnt", Stall_Count, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Shadow-pipeline hazard tracker for the 5-stage RV32I core. It records destination-register metadata for the instructions in EX, MEM and WB, and produces per-operand forwarding selects plus the `Fw_Detected` code and MEM-stage load flag consumed by the stall controller. It also obeys that controller's enable and flush outputs, so its slots always mirror the datapath pipeline registers. All outputs are decoded from registered slot state, so there is no combinational path from the stall controller back into this block.

## Interface
- `WIDTH_DATA_LENGTH`, 32, instruction width.
- `No_Fw` / `WB_Fw` / `MEM_Fw`, 2'b00 / 2'b01 / 2'b10, forwarding codes.
- `CNT_WIDTH`, 16, width of the stall/flush counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Inst_DE`  in  32  instruction currently in decode (FE/DE register output).
- `DE_EX_Reg_EN`  in  1  load enable for the EX slot.
- `DE_EX_Reg_RST`  in  1  flush of the EX slot (branch bubble).
- `EX_MEM_Reg_RST`  in  1  flush of the MEM slot (load-use bubble).
- `Stall_Detected`  in  1  load-use stall active this cycle.
- `Fw_Sel_Rs1`, `Fw_Sel_Rs2`  out  2 each  operand mux select for the EX instruction.
- `Fw_Detected`  out  2  combined code for the stall controller.
- `Mem_Load`  out  1  MEM slot holds a valid load.
- `Stall_Count`, `Flush_Count`  out  `CNT_WIDTH` each  saturating event counters.

## Operation
- **Slot contents.** Each slot holds {valid, rd[4:0], rs1[4:0], rs2[4:0], use_rs1, use_rs2, reg_wr, is_load}.
- **Decode of `Inst_DE[6:0]`.**
  - reg_wr is set for 0000011, 0010011, 0010111, 0110011, 0110111, 1101111 and 1100111.
  - use_rs1 is set for every opcode except 0110111, 0010111 and 1101111.
  - use_rs2 is set for 0110011, 0100011 and 1100011.
  - is_load is set for 0000011.
  - Unknown opcodes decode to all-zero flags.
  - rd = `Inst_DE[11:7]`, rs1 = `[19:15]`, rs2 = `[24:20]`.
- **Slot update, each clock.**
  - EX: `rst` or `DE_EX_Reg_RST` clears it (valid=0). Otherwise, if `DE_EX_Reg_EN`, it loads the decoded `Inst_DE`. Otherwise it holds.
  - MEM: `rst` or `EX_MEM_Reg_RST` clears it. Otherwise it loads EX.
  - WB: `rst` clears it. Otherwise it loads MEM.
  - If `DE_EX_Reg_RST` and `EX_MEM_Reg_RST` are asserted in the same cycle, both slots clear.
- **Match condition.** A slot S matches operand r when S.valid, S.reg_wr, S.rd≠0, EX.use_r and S.rd==EX.r all hold.
- **`Fw_Sel_RsN`.** `MEM_Fw` if MEM matches; else `WB_Fw` if WB matches; else `No_Fw`. MEM has priority over WB. Outputs are `No_Fw` when EX.valid=0.
- **`Fw_Detected`.** `MEM_Fw` if either select is `MEM_Fw`; else `WB_Fw` if either select is `WB_Fw`; else `No_Fw`.
- **`Mem_Load`.** Equals MEM.valid & MEM.is_load.
- **Counters.**
  - `Stall_Count` increments on each cycle with `Stall_Detected`=1.
  - `Flush_Count` increments on each cycle with `DE_EX_Reg_RST`=1.
  - Both saturate at all-ones, never wrap, and clear on `rst`.

## Timing
- Reset value of every output is zero: selects and `Fw_Detected` = `No_Fw`, `Mem_Load`=0, counters=0.
- Decode-to-EX-slot latency is 1 clock, and the slot advances one stage per clock.
- Outputs are valid in the same cycle from slot registers. `Inst_DE` and the enable/flush inputs affect outputs only after the next edge.
- **Load-use sequence.** The load is in MEM and the EX consumer sees `MEM_Fw`, so the controller stalls.
  - Next cycle: EX holds, MEM is a bubble, the load is in WB, and the consumer now sees `WB_Fw`.
- `rst` asserted mid-stall clears all slots on that edge. The counters do not count the reset cycle.

## Structure
- **Shared package `hazard_pkg`:**
  - opcode constants;
  - the forwarding codes `No_Fw`/`WB_Fw`/`MEM_Fw`;
  - the slot struct typedef.
- **Sub-module `hazard_decode`:** combinational `Inst_DE` to slot-fields decoder, instantiated once.

## Test plan
- **Back-to-back dependency.** `add x5,x1,x2` then `sub x6,x5,x3` → at EX of `sub`, `Fw_Sel_Rs1`=`MEM_Fw`, `Fw_Detected`=`MEM_Fw`, `Fw_Sel_Rs2`=`No_Fw`.
- **Load-use.** `lw x7,0(x1)` then `add x8,x7,x7` → `Mem_Load`=1 and both selects `MEM_Fw`. Drive `Stall_Detected`=1, `DE_EX_Reg_EN`=0, `EX_MEM_Reg_RST`=1 → next cycle both selects `WB_Fw`, MEM.valid=0, `Stall_Count`=1.
- **x0 and priority.** Writes to x0 never forward. Two in-flight writes to x9 with an EX read of x9 → `MEM_Fw`, not `WB_Fw`.
- **Branch flush.** `DE_EX_Reg_RST`=1 for 1 cycle → EX bubble, all selects `No_Fw` next cycle, `Flush_Count`=1. Simultaneous `EX_MEM_Reg_RST` also empties MEM.
- **Saturation and reset.** Preload `Stall_Count`=16'hFFFE and hold `Stall_Detected` for 3 cycles → reads 16'hFFFF and stays there. Assert `rst` mid-stream → all outputs 0 on the next cycle.
